// File: rtl/flash_sample_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : flash_sample_sequencer
//  Purpose  : Walks a programmable flash word range forward or backward,
//             unpacks LANES = WORD_W/SAMPLE_W samples per word and presents
//             one sample per sample_tick. The next word is prefetched through
//             a single-outstanding rd_req/rd_ack handshake. Supports pause,
//             one-shot or looping playback and restart.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W       flash word address width
//    WORD_W       flash data word width
//    SAMPLE_W     audio sample width (WORD_W/SAMPLE_W must be a power of two)
//  Ports
//    clk          system clock (single clock domain)
//    reset        asynchronous active-high reset
//    sample_tick  one-cycle strobe at the audio sample rate
//    play         1 = run, 0 = pause
//    dir          1 = ascending addresses, 0 = descending
//    loop_en      1 = wrap at range end, 0 = stop after the last word
//    restart      one-cycle pulse, restart from the range head
//    start_addr   first word of the range (inclusive)
//    end_addr     last word of the range (inclusive)
//    rd_req       flash read request, held until the rd_ack cycle
//    rd_addr      flash word address, stable while rd_req = 1
//    rd_ack       one-cycle pulse, rd_data valid and request complete
//    rd_data      flash read data
//    audio_out    current sample (registered)
//    audio_valid  one-cycle pulse when audio_out carries a new real sample
//    done         high while the sequencer sits in DONE
//    underrun     one-cycle pulse when a tick finds no sample data
//  Build option
//    FLASH_SEQ_UNDERRUN_CNT_EN  adds underrun_count[15:0], a saturating count
//                               of underrun pulses cleared by reset/restart
// ============================================================================
module flash_sample_sequencer #(
    parameter int ADDR_W   = 23,
    parameter int WORD_W   = 32,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_tick,
    input  logic                play,
    input  logic                dir,
    input  logic                loop_en,
    input  logic                restart,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   end_addr,
    output logic                rd_req,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic                rd_ack,
    input  logic [WORD_W-1:0]   rd_data,
    output logic [SAMPLE_W-1:0] audio_out,
    output logic                audio_valid,
    output logic                done,
    output logic                underrun
`ifdef FLASH_SEQ_UNDERRUN_CNT_EN
    ,
    output logic [15:0]         underrun_count
`endif
);

    localparam int LANES  = WORD_W / SAMPLE_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [LANE_W-1:0] c_LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [LANE_W-1:0] c_LANE_ONE  = LANE_W'(1);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_FILL = 2'd1;
    localparam logic [1:0] c_PLAY = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_play_d;

    logic [WORD_W-1:0]   r_cur_word;
    logic                r_cur_valid;   // cur_word still has unplayed lanes
    logic                r_cur_dir;     // lane order of the word in cur_word
    logic [LANE_W-1:0]   r_lane;        // lanes already played from cur_word

    logic [WORD_W-1:0]   r_nxt_word;
    logic                r_nxt_valid;
    logic                r_nxt_dir;

    logic                r_req;
    logic [ADDR_W-1:0]   r_req_addr;
    logic                r_req_dir;     // dir sampled when the request issued
    logic                r_discard;     // drop the data of the request in flight
    logic                r_started;     // head word has been requested
    logic                r_fetch_end;   // one-shot range exhausted, no more fetches
    logic [ADDR_W-1:0]   r_last_addr;   // address of the most recent request

    logic [SAMPLE_W-1:0] r_audio;
    logic                r_audio_valid;
    logic                r_done;
    logic                r_underrun;

    // ------------------------------------------------------------------
    // Lane extraction
    // ------------------------------------------------------------------
    logic [SAMPLE_W-1:0] w_lanes [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_lanes[g] = r_cur_word[g*SAMPLE_W +: SAMPLE_W];
    end

    logic [LANE_W-1:0]   w_phys_lane;
    logic [SAMPLE_W-1:0] w_sample;

    // Descending words play from the top lane down.
    assign w_phys_lane = r_cur_dir ? r_lane : (c_LAST_LANE - r_lane);
    assign w_sample    = w_lanes[w_phys_lane];

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    logic w_play_rise;
    logic w_restart_evt;
    logic w_bad_range;
    logic w_ack_ok;
    logic w_tick;
    logic w_last_lane;
    logic w_consume;
    logic w_take_nxt;
    logic w_drain;
    logic w_starved;
    logic w_finish;
    logic w_underrun;
    logic w_ack_to_cur;
    logic w_ack_to_nxt;

    assign w_play_rise   = play & ~r_play_d;
    // A play rising edge only starts playback out of IDLE; in PLAY it resumes.
    assign w_restart_evt = restart | ((r_state == c_IDLE) & w_play_rise);
    assign w_bad_range   = (start_addr > end_addr);

    // Acks without a pending request, or for a discarded request, are dropped.
    // An ack colliding with a restart belongs to the old range.
    assign w_ack_ok      = rd_ack & r_req & ~r_discard & ~w_restart_evt;

    assign w_tick        = sample_tick & play & ~w_restart_evt & (r_state == c_PLAY);
    assign w_last_lane   = (r_lane == c_LAST_LANE);
    assign w_consume     = w_tick & r_cur_valid;
    assign w_take_nxt    = w_consume & w_last_lane & r_nxt_valid;
    assign w_drain       = w_consume & w_last_lane & ~r_nxt_valid;
    assign w_starved     = w_tick & ~r_cur_valid;
    assign w_finish      = w_starved & r_fetch_end & ~r_req;
    assign w_underrun    = w_starved & ~w_finish;

    // cur_word is refilled first; an ack landing as the last lane drains it
    // goes straight into cur_word so no sample is lost.
    assign w_ack_to_cur  = w_ack_ok & (~r_cur_valid | w_drain);
    assign w_ack_to_nxt  = w_ack_ok & ~w_ack_to_cur;

    // ------------------------------------------------------------------
    // Request decision
    // ------------------------------------------------------------------
    logic              w_issue_ok;
    logic              w_slot_free;
    logic              w_at_end;
    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_head;
    logic              w_issue_head;
    logic              w_want_pf;
    logic              w_range_end;
    logic              w_issue;
    logic [ADDR_W-1:0] w_issue_addr;

    // Pause blocks new requests; a request in flight still completes.
    assign w_issue_ok   = play & ~w_restart_evt & ~r_req &
                          ((r_state == c_FILL) | (r_state == c_PLAY));
    // The prefetch slot frees in the very cycle cur_word takes nxt_word.
    assign w_slot_free  = ~r_nxt_valid | w_take_nxt;
    assign w_at_end     = dir ? (r_last_addr == end_addr) : (r_last_addr == start_addr);
    assign w_step       = dir ? (r_last_addr + c_ADDR_ONE) : (r_last_addr - c_ADDR_ONE);
    assign w_head       = dir ? start_addr : end_addr;

    assign w_issue_head = w_issue_ok & ~r_started;
    assign w_want_pf    = w_issue_ok & r_started & ~r_fetch_end & w_slot_free;
    assign w_range_end  = w_want_pf & w_at_end & ~loop_en;
    assign w_issue      = w_issue_head | (w_want_pf & ~w_range_end);
    // Wrap target equals the head for the current direction.
    assign w_issue_addr = (w_issue_head | w_at_end) ? w_head : w_step;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_restart_evt) begin
            w_state_nxt = w_bad_range ? c_DONE : c_FILL;
        end else begin
            case (r_state)
                c_FILL:  if (r_cur_valid) w_state_nxt = c_PLAY;
                c_PLAY:  if (w_finish)    w_state_nxt = c_DONE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (next values of the registered outputs)
    // ------------------------------------------------------------------
    logic [SAMPLE_W-1:0] w_audio_d;
    logic                w_valid_d;
    logic                w_underrun_d;
    logic                w_done_d;

    always_comb begin
        w_audio_d    = r_audio;
        w_valid_d    = w_consume;
        w_underrun_d = w_underrun;
        w_done_d     = (w_state_nxt == c_DONE);
        if (w_restart_evt || !play || (r_state != c_PLAY) || w_starved) begin
            w_audio_d = '0;
        end else if (w_consume) begin
            w_audio_d = w_sample;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_audio       <= '0;
            r_audio_valid <= 1'b0;
            r_done        <= 1'b0;
            r_underrun    <= 1'b0;
            r_play_d      <= 1'b0;
        end else begin
            r_audio       <= w_audio_d;
            r_audio_valid <= w_valid_d;
            r_done        <= w_done_d;
            r_underrun    <= w_underrun_d;
            r_play_d      <= play;
        end
    end

    // ------------------------------------------------------------------
    // Request channel
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req       <= 1'b0;
            r_req_addr  <= '0;
            r_req_dir   <= 1'b0;
            r_discard   <= 1'b0;
            r_started   <= 1'b0;
            r_fetch_end <= 1'b0;
            r_last_addr <= '0;
        end else begin
            if (r_req && rd_ack) begin
                r_req     <= 1'b0;
                r_discard <= 1'b0;
            end else if (w_issue) begin
                r_req      <= 1'b1;
                r_req_addr <= w_issue_addr;
                r_req_dir  <= dir;
            end

            // Keep the stale request on the bus until it acks, then drop it.
            if (w_restart_evt && r_req && !rd_ack) begin
                r_discard <= 1'b1;
            end

            if (w_restart_evt) begin
                r_started   <= 1'b0;
                r_fetch_end <= 1'b0;
            end else begin
                if (w_issue_head) r_started   <= 1'b1;
                if (w_range_end)  r_fetch_end <= 1'b1;
            end

            if (w_issue) begin
                r_last_addr <= w_issue_addr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Word buffers and lane counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur_word  <= '0;
            r_cur_valid <= 1'b0;
            r_cur_dir   <= 1'b0;
            r_lane      <= '0;
            r_nxt_word  <= '0;
            r_nxt_valid <= 1'b0;
            r_nxt_dir   <= 1'b0;
        end else if (w_restart_evt) begin
            r_cur_valid <= 1'b0;
            r_nxt_valid <= 1'b0;
            r_lane      <= '0;
        end else begin
            if (w_ack_to_cur) begin
                r_cur_word  <= rd_data;
                r_cur_dir   <= r_req_dir;
                r_cur_valid <= 1'b1;
                r_lane      <= '0;
            end else if (w_take_nxt) begin
                r_cur_word  <= r_nxt_word;
                r_cur_dir   <= r_nxt_dir;
                r_lane      <= '0;
            end else if (w_drain) begin
                r_cur_valid <= 1'b0;
                r_lane      <= '0;
            end else if (w_consume) begin
                r_lane      <= r_lane + c_LANE_ONE;
            end

            // nxt_word cannot be valid while a request is outstanding,
            // so these two never coincide.
            if (w_ack_to_nxt) begin
                r_nxt_word  <= rd_data;
                r_nxt_dir   <= r_req_dir;
                r_nxt_valid <= 1'b1;
            end else if (w_take_nxt) begin
                r_nxt_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional underrun counter
    // ------------------------------------------------------------------
`ifdef FLASH_SEQ_UNDERRUN_CNT_EN
    logic [15:0] r_ucnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ucnt <= '0;
        end else if (restart) begin
            r_ucnt <= '0;
        end else if (w_underrun && (r_ucnt != 16'hFFFF)) begin
            r_ucnt <= r_ucnt + 16'd1;
        end
    end

    assign underrun_count = r_ucnt;
`endif

    assign rd_req      = r_req;
    assign rd_addr     = r_req_addr;
    assign audio_out   = r_audio;
    assign audio_valid = r_audio_valid;
    assign done        = r_done;
    assign underrun    = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_flash_sample_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flash_sample_sequencer
//  Purpose  : Directed self-checking bench for flash_sample_sequencer with a
//             behavioural flash model of programmable ack latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_flash_sample_sequencer;

    localparam int GAP = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_tick;
    logic        play;
    logic        dir;
    logic        loop_en;
    logic        restart;
    logic [22:0] start_addr;
    logic [22:0] end_addr;
    logic        rd_req;
    logic [22:0] rd_addr;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic [15:0] audio_out;
    logic        audio_valid;
    logic        done;
    logic        underrun;
`ifdef FLASH_SEQ_UNDERRUN_CNT_EN
    logic [15:0] underrun_count;
`endif

    flash_sample_sequencer #(
        .ADDR_W   (23),
        .WORD_W   (32),
        .SAMPLE_W (16)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .play        (play),
        .dir         (dir),
        .loop_en     (loop_en),
        .restart     (restart),
        .start_addr  (start_addr),
        .end_addr    (end_addr),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_data     (rd_data),
        .audio_out   (audio_out),
        .audio_valid (audio_valid),
        .done        (done),
        .underrun    (underrun)
`ifdef FLASH_SEQ_UNDERRUN_CNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Flash model: captures a request, acks it lat cycles later
    // ------------------------------------------------------------------
    logic [31:0] mem [256];
    logic [22:0] addr_log [$];
    logic [22:0] cap_addr;
    bit          busy;
    int          cnt;
    int          lat;

    initial begin
        rd_ack   = 1'b0;
        rd_data  = '0;
        busy     = 1'b0;
        cnt      = 0;
        lat      = 4;
        cap_addr = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hAAAA5555;
        mem[8'h11] = 32'hCCCC3333;
        mem[8'h20] = 32'h1234BEEF;
        mem[8'h21] = 32'h56789ABC;
    end

    always @(negedge clk) begin
        rd_ack = 1'b0;
        if (busy) begin
            cnt = cnt - 1;
            if (cnt <= 0) begin
                rd_ack  = 1'b1;
                rd_data = mem[cap_addr[7:0]];
                busy    = 1'b0;
            end
        end else if (rd_req === 1'b1) begin
            busy     = 1'b1;
            cnt      = lat;
            cap_addr = rd_addr;
            addr_log.push_back(rd_addr);
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (i < addr_log.size()) return 32'(addr_log[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic tick(output logic [15:0] a, output logic v, output logic u, output logic d);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        a = audio_out;
        v = audio_valid;
        u = underrun;
        d = done;
    endtask

    // Expect a real sample: underrun=0, valid=1, audio=exp.
    task automatic tick_expect(input string tag, input logic [15:0] exp);
        logic [15:0] a;
        logic        v, u, d;
        tick(a, v, u, d);
        check(tag, {14'd0, u, v, a}, {14'd0, 1'b0, 1'b1, exp});
        repeat (GAP) @(negedge clk);
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic wait_log(input string tag, input int n, input int bound);
        int k;
        k = 0;
        while (addr_log.size() < n && k < bound) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(addr_log.size() >= n), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        logic [15:0] a;
        logic        v, u, d;
        int          bad;
        int          req_seen;
        int          log_before;

        reset       = 1'b1;
        sample_tick = 1'b0;
        play        = 1'b0;
        dir         = 1'b1;
        loop_en     = 1'b1;
        restart     = 1'b0;
        start_addr  = 23'h10;
        end_addr    = 23'h11;

        repeat (3) @(negedge clk);
        check("reset_ctl", {28'd0, rd_req, audio_valid, done, underrun}, 32'd0);
        check("reset_audio", 32'(audio_out), 32'd0);
        reset = 1'b0;

        // ---- ascending loop playback ----
        @(negedge clk);
        play    = 1'b1;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        repeat (30) @(negedge clk);
        tick_expect("up_s0", 16'h5555);
        tick_expect("up_s1", 16'hAAAA);
        tick_expect("up_s2", 16'h3333);
        tick_expect("up_s3", 16'hCCCC);
        tick_expect("up_wrap", 16'h5555);
        check("up_addr0", log_at(0), 32'h10);
        check("up_addr1", log_at(1), 32'h11);
        check("up_addr2", log_at(2), 32'h10);
        check("up_addr3", log_at(3), 32'h11);

        // ---- descending one-shot ----
        repeat (20) @(negedge clk);
        dir     = 1'b0;
        loop_en = 1'b0;
        addr_log.delete();
        pulse_restart();
        repeat (30) @(negedge clk);
        tick_expect("dn_s0", 16'hCCCC);
        tick_expect("dn_s1", 16'h3333);
        tick_expect("dn_s2", 16'hAAAA);
        tick_expect("dn_s3", 16'h5555);
        tick(a, v, u, d);
        check("dn_done", {13'd0, d, u, v, a}, {13'd0, 1'b1, 1'b0, 1'b0, 16'h0});
        repeat (20) @(negedge clk);
        check("dn_nreq", 32'(addr_log.size()), 32'd2);
        check("dn_addr0", log_at(0), 32'h11);
        check("dn_addr1", log_at(1), 32'h10);
        check("dn_done_hold", {31'd0, done}, 32'd1);

        // ---- pause and resume ----
        dir     = 1'b1;
        loop_en = 1'b1;
        addr_log.delete();
        pulse_restart();
        repeat (30) @(negedge clk);
        tick_expect("ps_s0", 16'h5555);
        tick_expect("ps_s1", 16'hAAAA);
        tick_expect("ps_s2", 16'h3333);
        play       = 1'b0;
        log_before = addr_log.size();
        bad        = 0;
        req_seen   = 0;
        for (int i = 0; i < 50; i++) begin
            tick(a, v, u, d);
            if (v !== 1'b0 || a !== 16'h0) bad++;
            if (rd_req !== 1'b0) req_seen++;
        end
        check("ps_quiet", 32'(bad), 32'd0);
        check("ps_rdreq", 32'(req_seen), 32'd0);
        check("ps_nreq", 32'(addr_log.size()), 32'(log_before));
        play = 1'b1;
        repeat (2) @(negedge clk);
        tick_expect("ps_resume", 16'hCCCC);

        // ---- slow flash: underrun then recovery ----
        addr_log.delete();
        pulse_restart();
        repeat (30) @(negedge clk);
        lat = 80;
        tick_expect("ur_s0", 16'h5555);
        tick_expect("ur_s1", 16'hAAAA);
        tick_expect("ur_s2", 16'h3333);
        tick_expect("ur_s3", 16'hCCCC);
        tick(a, v, u, d);
        check("ur_starve0", {14'd0, u, v, a}, {14'd0, 1'b1, 1'b0, 16'h0});
        repeat (GAP) @(negedge clk);
        tick(a, v, u, d);
        check("ur_starve1", {14'd0, u, v, a}, {14'd0, 1'b1, 1'b0, 16'h0});
        repeat (80) @(negedge clk);
        lat = 4;
        tick_expect("ur_recover0", 16'h5555);
        tick_expect("ur_recover1", 16'hAAAA);

        // ---- reset with a request in flight, late ack ----
        repeat (20) @(negedge clk);
        lat = 20;
        addr_log.delete();
        pulse_restart();
        wait_log("rs_reqseen", 1, 20);
        #2;
        reset = 1'b1;
        #1;
        check("rs_async", {27'd0, rd_req, audio_valid, done, underrun, |audio_out}, 32'd0);
        play = 1'b0;
        repeat (3) @(negedge clk);
        reset    = 1'b0;
        req_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rd_req !== 1'b0) req_seen++;
        end
        check("rs_idle_req", 32'(req_seen), 32'd0);
        tick(a, v, u, d);
        check("rs_idle_tick", {14'd0, u, v, a}, 32'd0);
        lat        = 4;
        start_addr = 23'h11;
        end_addr   = 23'h11;
        play       = 1'b1;
        repeat (30) @(negedge clk);
        tick_expect("rs_first", 16'h3333);
        tick_expect("rs_second", 16'hCCCC);

        // ---- restart while a prefetch is in flight ----
        play       = 1'b0;
        repeat (20) @(negedge clk);
        start_addr = 23'h10;
        end_addr   = 23'h11;
        play       = 1'b1;
        addr_log.delete();
        pulse_restart();
        wait_log("rt_head", 1, 20);
        lat = 40;
        wait_log("rt_pf", 2, 30);
        check("rt_pf_addr", log_at(1), 32'h11);
        start_addr = 23'h20;
        end_addr   = 23'h21;
        lat        = 4;
        @(negedge clk);
        restart     = 1'b1;
        sample_tick = 1'b1;
        @(negedge clk);
        restart     = 1'b0;
        sample_tick = 1'b0;
        check("rt_tick_ignored", {31'd0, audio_valid}, 32'd0);
        wait_log("rt_newreq", 3, 80);
        check("rt_new_addr", log_at(2), 32'h20);
        repeat (20) @(negedge clk);
        tick_expect("rt_s0", 16'hBEEF);
        tick_expect("rt_s1", 16'h1234);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
